// File: rtl/mips_pkg.sv
// Shared constants for the MIPS data-memory slice: MMIO register offsets and CTRL bit layout.
package mips_pkg;
  localparam int DATA_MEM_WIDTH = 32;

  localparam logic [3:0] MMIO_LED_OFF   = 4'h0;
  localparam logic [3:0] MMIO_COUNT_OFF = 4'h4;
  localparam logic [3:0] MMIO_CMP_OFF   = 4'h8;
  localparam logic [3:0] MMIO_CTRL_OFF  = 4'hC;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;
  localparam int CTRL_ST_BIT = 2;
endpackage

// File: rtl/mips_mmio_timer.sv
// Auto-reload compare timer (COUNT/CMP/CTRL) with a sticky, write-1-to-clear status flag.
// Only compiled when MIPS_DMEM_TIMER_EN is defined.
`ifdef MIPS_DMEM_TIMER_EN
module mips_mmio_timer
  import mips_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [3:0]                off,
  input  logic [DATA_MEM_WIDTH-1:0] wdata,
  output logic [DATA_MEM_WIDTH-1:0] rdata,
  output logic                      timer_irq
);
  logic [DATA_MEM_WIDTH-1:0] count, cmp;
  logic en, ie, st;
  logic match, ctrl_we;

  // Compare always sees the pre-edge EN/CMP, so writes to them act from the next cycle.
  assign match   = en && (count == cmp);
  assign ctrl_we = we && (off == MMIO_CTRL_OFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      cmp   <= '1;
      en    <= 1'b0;
      ie    <= 1'b0;
      st    <= 1'b0;
    end else begin
      if (en) count <= match ? '0 : count + 1'b1;
      if (we && off == MMIO_CMP_OFF) cmp <= wdata;
      if (ctrl_we) begin
        en <= wdata[CTRL_EN_BIT];
        ie <= wdata[CTRL_IE_BIT];
      end
      // Set beats clear when both land on the same edge.
      st <= match | (st & ~(ctrl_we & wdata[CTRL_ST_BIT]));
    end
  end

  always_comb begin
    rdata = '0;
    unique case (off)
      MMIO_COUNT_OFF: rdata = count;
      MMIO_CMP_OFF:   rdata = cmp;
      MMIO_CTRL_OFF: begin
        rdata[CTRL_EN_BIT] = en;
        rdata[CTRL_IE_BIT] = ie;
        rdata[CTRL_ST_BIT] = st;
      end
      default:        rdata = '0;
    endcase
  end

  assign timer_irq = st & ie;
endmodule
`endif

// File: rtl/mips_data_mem.sv
// Word-addressed data RAM plus MMIO window (LED, optional timer under MIPS_DMEM_TIMER_EN).
// Reads are combinational for the single-cycle core; writes land on the clock edge.
module mips_data_mem
  import mips_pkg::*;
#(
  parameter int                        RAM_DEPTH = 64,
  parameter logic [DATA_MEM_WIDTH-1:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      memwrite,
  input  logic [DATA_MEM_WIDTH-1:0] memaddr,
  input  logic [DATA_MEM_WIDTH-1:0] writedata,
  output logic [DATA_MEM_WIDTH-1:0] readdata,
  output logic [15:0]               led,
  output logic                      timer_irq,
  output logic                      addr_err
);
  localparam int                        AW        = $clog2(RAM_DEPTH);
  localparam logic [DATA_MEM_WIDTH-1:0] RAM_BYTES = DATA_MEM_WIDTH'(RAM_DEPTH * 4);

  logic [DATA_MEM_WIDTH-1:0] ram [RAM_DEPTH];
  logic [AW-1:0]             ram_idx;
  logic [3:0]                off;
  logic                      in_ram, in_mmio;
  logic [DATA_MEM_WIDTH-1:0] tmr_rdata;

  assign ram_idx = memaddr[AW+1:2];
  assign off     = {memaddr[3:2], 2'b00};
  assign in_ram  = memaddr < RAM_BYTES;
  assign in_mmio = memaddr[31:4] == MMIO_BASE[31:4];

  always_ff @(posedge clk) begin
    if (memwrite && in_ram) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= '0;
      addr_err <= 1'b0;
    end else begin
      if (memwrite && in_mmio && off == MMIO_LED_OFF) led <= writedata[15:0];
      addr_err <= memwrite && !in_ram && !in_mmio;
    end
  end

`ifdef MIPS_DMEM_TIMER_EN
  mips_mmio_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .we       (memwrite && in_mmio),
    .off      (off),
    .wdata    (writedata),
    .rdata    (tmr_rdata),
    .timer_irq(timer_irq)
  );
`else
  assign tmr_rdata = '0;
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    if (in_ram)
      readdata = ram[ram_idx];
    else if (in_mmio)
      readdata = (off == MMIO_LED_OFF) ? {16'h0, led} : tmr_rdata;
  end
endmodule

// File: tb/tb_mips_data_mem.sv
// Directed self-checking bench for mips_data_mem; timer scenarios follow MIPS_DMEM_TIMER_EN.
module tb_mips_data_mem;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] LED_A = BASE + 32'h0;
  localparam logic [31:0] CNT_A = BASE + 32'h4;
  localparam logic [31:0] CMP_A = BASE + 32'h8;
  localparam logic [31:0] CTL_A = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] memaddr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [15:0] led;
  logic        timer_irq, addr_err;

  int checks = 0;
  int failures = 0;

  mips_data_mem #(.RAM_DEPTH(64), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .memwrite(memwrite), .memaddr(memaddr),
    .writedata(writedata), .readdata(readdata), .led(led),
    .timer_irq(timer_irq), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Drive a write in the low phase, return 1 time unit after the capturing edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b1; memaddr = a; writedata = d;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    memwrite = 1'b0; memaddr = a; #1;
  endtask

  task automatic test_reset();
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", led); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
    rd(LED_A);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_led_rd got=%h exp=0", readdata); end
`ifdef MIPS_DMEM_TIMER_EN
    rd(CMP_A);
    checks++; if (readdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp got=%h exp=ffffffff", readdata); end
    rd(CTL_A);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", readdata); end
`endif
  endtask

  task automatic test_ram();
    wr(32'h14, 32'h1111_1111);
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10);
    checks++; if (readdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd10 got=%h exp=deadbeef", readdata); end
    rd(32'h13);
    checks++; if (readdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd13 got=%h exp=deadbeef", readdata); end
    rd(32'h14);
    checks++; if (readdata !== 32'h1111_1111) begin failures++; $display("FAIL ram_rd14 got=%h exp=11111111", readdata); end
    wr(32'h0, 32'h0000_0A0A);
    wr(32'hFC, 32'hCAFE_F00D);
    rd(32'hFC);
    checks++; if (readdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_top got=%h exp=cafef00d", readdata); end
    rd(32'h0);
    checks++; if (readdata !== 32'h0000_0A0A) begin failures++; $display("FAIL ram_word0 got=%h exp=00000a0a", readdata); end
    // Same-cycle read of a word being written shows the old value.
    @(negedge clk);
    memwrite = 1'b1; memaddr = 32'h10; writedata = 32'h5555_AAAA; #1;
    checks++; if (readdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd_during_wr got=%h exp=deadbeef", readdata); end
    @(posedge clk); #1; memwrite = 1'b0; #1;
    checks++; if (readdata !== 32'h5555_AAAA) begin failures++; $display("FAIL ram_rd_after_wr got=%h exp=5555aaaa", readdata); end
    wr(32'h10, 32'hDEAD_BEEF);
  endtask

  task automatic test_led();
    @(negedge clk);
    memwrite = 1'b1; memaddr = LED_A; writedata = 32'h0001_ABCD; #1;
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL led_same_cycle got=%h exp=0", readdata); end
    @(posedge clk); #1; memwrite = 1'b0; #1;
    checks++; if (led !== 16'hABCD) begin failures++; $display("FAIL led_out got=%h exp=abcd", led); end
    checks++; if (readdata !== 32'h0000_ABCD) begin failures++; $display("FAIL led_rd got=%h exp=0000abcd", readdata); end
  endtask

  task automatic test_unmapped();
    wr(32'h8000_0000, 32'h1234_5678);
    checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL unmapped_err_set got=%b exp=1", addr_err); end
    @(posedge clk); #1;
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL unmapped_err_pulse got=%b exp=0", addr_err); end
    rd(32'h8000_0000);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL unmapped_rd got=%h exp=0", readdata); end
    checks++; if (led !== 16'hABCD) begin failures++; $display("FAIL unmapped_led got=%h exp=abcd", led); end
    // First byte past RAM would alias word 0 if decode only used the index bits.
    wr(32'h0000_0100, 32'hBAD0_BAD0);
    checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL ram_end_err got=%b exp=1", addr_err); end
    rd(32'h0);
    checks++; if (readdata !== 32'h0000_0A0A) begin failures++; $display("FAIL ram_end_alias got=%h exp=00000a0a", readdata); end
    wr(BASE + 32'h10, 32'h0000_FFFF);
    checks++; if (addr_err !== 1'b1 || led !== 16'hABCD) begin failures++; $display("FAIL mmio_end got err=%b led=%h exp err=1 led=abcd", addr_err, led); end
    rd(BASE + 32'h10);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL mmio_end_rd got=%h exp=0", readdata); end
  endtask

`ifdef MIPS_DMEM_TIMER_EN
  task automatic test_timer();
    logic [31:0] exp_cnt [6];
    bit found;
    exp_cnt = '{0, 1, 2, 3, 4, 0};
    wr(CNT_A, 32'h0000_0077);
    rd(CNT_A);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL count_ro got=%h exp=0", readdata); end
    wr(CMP_A, 32'd4);
    wr(CTL_A, 32'h3);
    memaddr = CNT_A;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      checks++; if (readdata !== exp_cnt[k]) begin failures++; $display("FAIL count_seq%0d got=%h exp=%h", k, readdata, exp_cnt[k]); end
      checks++; if (timer_irq !== (k == 5)) begin failures++; $display("FAIL irq_seq%0d got=%b exp=%b", k, timer_irq, k == 5); end
    end
    wr(CTL_A, 32'h7);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
    rd(CTL_A);
    checks++; if (readdata !== 32'h3) begin failures++; $display("FAIL ctrl_after_clear got=%h exp=3", readdata); end
    // Line up a clear with the next match edge: set must win.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); memaddr = CNT_A; #1;
      if (readdata == 32'd4) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL match_wait timeout got=no_match exp=count4"); end
    memwrite = 1'b1; memaddr = CTL_A; writedata = 32'h7;
    @(posedge clk); #1; memwrite = 1'b0;
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL set_wins got=%b exp=1", timer_irq); end
  endtask
`else
  task automatic test_no_timer();
    wr(CMP_A, 32'd5);
    wr(CTL_A, 32'h3);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL notimer_irq got=%b exp=0", timer_irq); end
    rd(CNT_A);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL notimer_count got=%h exp=0", readdata); end
    rd(CMP_A);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL notimer_cmp got=%h exp=0", readdata); end
    rd(CTL_A);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL notimer_ctrl got=%h exp=0", readdata); end
  endtask
`endif

  task automatic test_reset_mid();
    wr(32'h8000_0004, 32'h1);
    #2 rst = 1'b1; #1;
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL rst_addr_err got=%b exp=0", addr_err); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL rst_led got=%h exp=0", led); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", timer_irq); end
`ifdef MIPS_DMEM_TIMER_EN
    rd(CNT_A);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL rst_count got=%h exp=0", readdata); end
    rd(CTL_A);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", readdata); end
    rd(CMP_A);
    checks++; if (readdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_cmp got=%h exp=ffffffff", readdata); end
`endif
    rd(32'h10);
    checks++; if (readdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rst_ram got=%h exp=deadbeef", readdata); end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #12 rst = 1'b0;
    #1;
    test_reset();
    test_ram();
    test_led();
    test_unmapped();
`ifdef MIPS_DMEM_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
